// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the 2-read/1-write register bank.
package reg_file_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once and zeroes it, then
// releases the bank.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy
);

    rf_state_t         state;
    logic [ADDR_W-1:0] clr_cnt;

    // The clear write is gated by rst_n so the array is untouched while reset is held.
    assign clr_we   = rst_n && (state == CLEAR);
    assign clr_addr = clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {ADDR_W{1'b1}}) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    state     <= READY;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_file_bank.sv
// 2-read/1-write register bank with registered reads and a post-reset clear.
// Optional write-first forwarding on same-edge read/write: REG_FILE_BYPASS_EN.
module reg_file_bank
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              user_we;
    logic              rd_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_next1;
    logic [DATA_W-1:0] rd_next2;

    reg_file_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    assign user_we   = rst_n && !init_busy && wr_en;
    assign rd_accept = rst_n && !init_busy && rd_en;

    // Clear sequencer owns the write port while busy; user writes are masked then.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else if (user_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

`ifdef REG_FILE_BYPASS_EN
    // Write-first: a read hitting this edge's write address sees the new data.
    always_comb begin
        rd_next1 = mem[rd_addr1];
        rd_next2 = mem[rd_addr2];
        if (user_we && (wr_addr == rd_addr1))
            rd_next1 = wr_data;
        if (user_we && (wr_addr == rd_addr2))
            rd_next2 = wr_data;
    end
`else
    // Read-first: same-edge reads return pre-write contents.
    always_comb begin
        rd_next1 = mem[rd_addr1];
        rd_next2 = mem[rd_addr2];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data1 <= rd_next1;
                rd_data2 <= rd_next2;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed self-checking bench for reg_file_bank (DATA_W=32, ADDR_W=4).
module tb_reg_file_bank;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_valid;
    logic              init_busy;

    int n_chk;
    int n_err;

    reg_file_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One active edge; outputs are sampled 1ns later, inputs changed there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            rd_en    = 1'b1;
            rd_addr1 = ADDR_W'(i);
            rd_addr2 = ADDR_W'(DEPTH - 1 - i);
            tick();
            chk({tag, "_d1"}, rd_data1, '0);
            chk({tag, "_d2"}, rd_data2, '0);
            chk({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
        end
        idle();
    endtask

    initial begin
        logic [DATA_W-1:0] exp_same;
        n_chk = 0;
        n_err = 0;
        idle();

        // Reset for two edges
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'b0, init_busy}, 32'd1);
        chk("rst_vld", {31'b0, rd_valid}, 32'd0);
        chk("rst_d1", rd_data1, '0);
        chk("rst_d2", rd_data2, '0);

        // Clear: busy for exactly 16 edges; write+read attempt at cycle 3 ignored
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            idle();
            if (i == 3) begin
                wr_en    = 1'b1;
                wr_addr  = 4'd7;
                wr_data  = 32'h77;
                rd_en    = 1'b1;
                rd_addr1 = 4'd7;
                rd_addr2 = 4'd7;
            end
            tick();
            chk($sformatf("clr_busy_%0d", i), {31'b0, init_busy}, (i < DEPTH) ? 32'd1 : 32'd0);
            chk($sformatf("clr_vld_%0d", i), {31'b0, rd_valid}, 32'd0);
        end
        chk("clr_d1_held", rd_data1, '0);
        read_all_zero("clr_rd");

        // Write then read two addresses
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        tick();
        wr_addr = 4'd2; wr_data = 32'h9;
        tick();
        idle();
        rd_en = 1'b1; rd_addr1 = 4'd3; rd_addr2 = 4'd2;
        tick();
        chk("wr_rd_d1", rd_data1, 32'hDEADBEEF);
        chk("wr_rd_d2", rd_data2, 32'h9);
        chk("wr_rd_vld", {31'b0, rd_valid}, 32'd1);

        // rd_en low: data held, valid drops
        idle();
        rd_addr1 = 4'd5; rd_addr2 = 4'd0;
        tick();
        chk("hold_d1", rd_data1, 32'hDEADBEEF);
        chk("hold_d2", rd_data2, 32'h9);
        chk("hold_vld", {31'b0, rd_valid}, 32'd0);
        rd_addr1 = 4'd12; rd_addr2 = 4'd3;
        tick();
        chk("hold2_d1", rd_data1, 32'hDEADBEEF);
        chk("hold2_d2", rd_data2, 32'h9);

        // Same-edge write/read of addr 5 (was 0)
`ifdef REG_FILE_BYPASS_EN
        exp_same = 32'h55;
`else
        exp_same = 32'h0;
`endif
        idle();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h55;
        rd_en = 1'b1; rd_addr1 = 4'd5; rd_addr2 = 4'd5;
        tick();
        chk("raw_d1", rd_data1, exp_same);
        chk("raw_d2", rd_data2, exp_same);
        idle();
        rd_en = 1'b1; rd_addr1 = 4'd5; rd_addr2 = 4'd5;
        tick();
        chk("raw_next_d1", rd_data1, 32'h55);
        chk("raw_next_d2", rd_data2, 32'h55);
        chk("raw_next_vld", {31'b0, rd_valid}, 32'd1);

        // Per-port forwarding: only port 1 hits the write address
`ifdef REG_FILE_BYPASS_EN
        exp_same = 32'hA1;
`else
        exp_same = 32'h0;
`endif
        idle();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hA1;
        rd_en = 1'b1; rd_addr1 = 4'd9; rd_addr2 = 4'd3;
        tick();
        chk("port_d1", rd_data1, exp_same);
        chk("port_d2", rd_data2, 32'hDEADBEEF);

        // Reset with a write pending, then re-reset at clear cycle 8
        idle();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h44;
        rst_n = 1'b0;
        tick();
        chk("rst2_busy", {31'b0, init_busy}, 32'd1);
        chk("rst2_d1", rd_data1, '0);
        chk("rst2_vld", {31'b0, rd_valid}, 32'd0);
        idle();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("mid_busy_%0d", i), {31'b0, init_busy}, 32'd1);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            chk($sformatf("reclr_busy_%0d", i), {31'b0, init_busy}, (i < DEPTH) ? 32'd1 : 32'd0);
        end
        read_all_zero("reclr_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
